mem_refill_ctrl: RTL and testbench
==================================

# mem_refill_ctrl

Miss-service controller directly downstream of the direct-mapped, write-back L1 data cache in the MEM stage. On a cache miss it writes the dirty 16-word victim line back to main memory, fetches the 16-word target line, and streams each fetched word into the cache array. Main-memory latency comes from a req/ack handshake instead of a fixed delay. `busy` feeds the MEM-stage stall.

## Interface
- `LINE_WORDS`, 16: words per cache line; fixed, with `idx` 4 bits wide.
- `ACK_TIMEOUT`, 64: cycles a single word may wait for `mem_ack` before `err` sets.
- `clock` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `miss_req` in 1: single-cycle miss request from the cache.
- `miss_line` in 26: line address of the missing line, addr[31:6].
- `victim_dirty` in 1: victim line is dirty and must be written back.
- `victim_line` in 26: line address of the victim, {tag, index}.
- `wb_idx` out 4: word index of the victim word the cache must present.
- `wb_data` in 32: victim word `cache[index][wb_idx]`, combinational from the cache.
- `fill_we` out 1: write strobe into the cache line.
- `fill_idx` out 4: word index for `fill_data`.
- `fill_data` out 32: refill word.
- `busy` out 1: a miss is in service; drives the stall.
- `done` out 1: one-cycle pulse when the line is complete; the cache updates tag and dirty on this pulse.
- `err` out 1: sticky timeout flag.
- `mem_req` out 1: main-memory request.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out 32: byte address, {line, idx, 2'b00}.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, valid while `mem_ack` = 1.
- `mem_ack` in 1: memory accepts or completes the current word.

## Operation
- States: IDLE, WB, FILL, DONE. Registers: `state`, `cnt[3:0]`, `miss_q[25:0]`, `vict_q[25:0]`, `wait_cnt`, `err`.
- IDLE
  - `miss_req` = 1 captures `miss_line` into `miss_q` and `victim_line` into `vict_q`, and clears `cnt`.
  - Next state is WB if `victim_dirty` = 1, otherwise FILL.
- WB
  - Outputs: `mem_req` = 1, `mem_we` = 1, `mem_addr` = {vict_q, cnt, 2'b00}, `wb_idx` = cnt, `mem_wdata` = `wb_data` (combinational pass-through).
  - `mem_ack` increments `cnt`.
  - `mem_ack` with `cnt` = 15 goes to FILL with `cnt` wrapping to 0.
- FILL
  - Outputs: `mem_req` = 1, `mem_we` = 0, `mem_addr` = {miss_q, cnt, 2'b00}.
  - While `mem_ack` = 1, combinationally: `fill_we` = 1, `fill_idx` = cnt, `fill_data` = `mem_rdata`.
  - `mem_ack` increments `cnt`; `mem_ack` with `cnt` = 15 goes to DONE.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- `busy` = 1 in WB, FILL and DONE.
- In IDLE every output is 0, except `wb_idx` = 0 and the sticky `err`.
- `miss_req` outside IDLE is ignored; it is not queued.
- `mem_ack` while `mem_req` = 0 is ignored.
- Write hits never reach this block. Merging the pending store into the line after refill is the cache's job, done on `done`.
- Timeout
  - `wait_cnt` clears on every `mem_ack` and on entry to WB or FILL, and increments each cycle `mem_req` is high without an ack.
  - When it reaches ACK_TIMEOUT, `err` sets and the FSM stays in its current state, still requesting.
  - `err` clears only on reset.
- Word-address arithmetic is 4-bit `cnt` concatenation; no carry into the line field.

## Timing
- Reset (`resetn` low, asynchronous)
  - state = IDLE, `cnt` = 0, `wait_cnt` = 0, `err` = 0.
  - All outputs 0 immediately.
  - Any in-flight memory transaction is abandoned. The cache line is left partially filled and its tag is not updated, because `done` never fires.
- The `miss_req` edge is cycle 0; `busy` rises in cycle 1.
- `mem_req` is held high with `mem_addr`, `mem_we` and `mem_wdata` stable until the edge on which `mem_ack` = 1.
- The next word's request is presented in the cycle after an ack (back-to-back when the ack stays high).
- With ack held high every cycle:
  - Clean miss: FILL in cycles 1-16, `done` in cycle 17, `busy` 1-17, idle in cycle 18.
  - Dirty miss: WB 1-16, FILL 17-32, `done` 33.
- A `miss_req` in the same cycle as `done` is ignored. A new `miss_req` is accepted from cycle 18 (clean) or cycle 34 (dirty).

## Test plan
- Reset: `resetn` = 0 mid-FILL at `cnt` = 7 -> `busy`/`mem_req`/`fill_we` drop to 0 asynchronously, `done` never pulses, and the next `miss_req` restarts with `cnt` = 0.
- Clean miss: `miss_line` = 26'h0000002, ack always high -> 16 reads at 32'h80, 84 … BC; `fill_idx` 0..15 carry `mem_rdata`; `done` in cycle 17; `busy` high for exactly 17 cycles.
- Dirty miss: `victim_line` = 26'h0000040, `miss_line` = 26'h0000041 -> writes at 32'h1000..103C with `mem_wdata` = `wb_data`[`wb_idx`], then reads at 32'h1040..107C; `done` in cycle 33.
- Slow memory: ack every 3rd cycle -> address held stable across the waits; a spurious `mem_ack` in IDLE produces no `fill_we`; `done` in cycle 49 for a clean miss.
- Timeout: `mem_ack` held low for 64 cycles in FILL -> `err` = 1 and `mem_req` still 1; later acks complete the line and `err` stays 1.
- `miss_req` pulsed while `busy` -> ignored; captured addresses unchanged.

Source files
------------

// File: rtl/mem_refill_ctrl.sv
// Miss-service controller for the write-back L1 data cache: writes back a dirty
// victim line, then refills the missing line word by word over a req/ack memory port.
`timescale 1ns/1ps
module mem_refill_ctrl #(
    parameter int unsigned LINE_WORDS  = 16,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        miss_req,
    input  logic [25:0] miss_line,
    input  logic        victim_dirty,
    input  logic [25:0] victim_line,
    output logic [3:0]  wb_idx,
    input  logic [31:0] wb_data,
    output logic        fill_we,
    output logic [3:0]  fill_idx,
    output logic [31:0] fill_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned WAIT_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [3:0]  LAST_IDX = 4'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic [25:0]       miss_q;
    logic [25:0]       vict_q;
    logic [WAIT_W-1:0] wait_cnt;

    always_comb begin
        state_nxt = state;
        wb_idx    = '0;
        fill_we   = 1'b0;
        fill_idx  = '0;
        fill_data = '0;
        busy      = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (miss_req)
                    state_nxt = victim_dirty ? WB : FILL;
            end
            WB: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {vict_q, cnt, 2'b00};
                wb_idx    = cnt;
                mem_wdata = wb_data;
                if (mem_ack && cnt == LAST_IDX)
                    state_nxt = FILL;
            end
            FILL: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {miss_q, cnt, 2'b00};
                if (mem_ack) begin
                    fill_we   = 1'b1;
                    fill_idx  = cnt;
                    fill_data = mem_rdata;
                    if (cnt == LAST_IDX)
                        state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            miss_q   <= '0;
            vict_q   <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;

            // cnt wraps 15 -> 0 naturally, which is the WB -> FILL handoff
            if (state == IDLE && miss_req) begin
                miss_q <= miss_line;
                vict_q <= victim_line;
                cnt    <= '0;
            end else if (mem_req && mem_ack) begin
                cnt <= cnt + 4'd1;
            end

            if (state_nxt != state && (state_nxt == WB || state_nxt == FILL))
                wait_cnt <= '0;
            else if (mem_req && mem_ack)
                wait_cnt <= '0;
            else if (mem_req && wait_cnt != WAIT_W'(ACK_TIMEOUT))
                wait_cnt <= wait_cnt + 1'b1;

            // err rises on the same edge wait_cnt reaches ACK_TIMEOUT
            if (mem_req && !mem_ack && wait_cnt == WAIT_W'(ACK_TIMEOUT - 1))
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Directed bench for mem_refill_ctrl: a scoreboard of expected memory words is
// filled per miss and drained as the controller issues acknowledged requests.
`timescale 1ns/1ps
module tb_mem_refill_ctrl;

    logic        clock = 1'b0;
    logic        resetn;
    logic        miss_req;
    logic [25:0] miss_line;
    logic        victim_dirty;
    logic [25:0] victim_line;
    logic [3:0]  wb_idx;
    logic [31:0] wb_data;
    logic        fill_we;
    logic [3:0]  fill_idx;
    logic [31:0] fill_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t sbq[$];

    logic s_busy, s_done, s_err, s_req;

    always #5 clock = ~clock;

    mem_refill_ctrl #(.LINE_WORDS(16), .ACK_TIMEOUT(64)) dut (
        .clock(clock), .resetn(resetn),
        .miss_req(miss_req), .miss_line(miss_line),
        .victim_dirty(victim_dirty), .victim_line(victim_line),
        .wb_idx(wb_idx), .wb_data(wb_data),
        .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
        .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    function automatic logic [31:0] wb_model(input logic [3:0] i);
        return 32'hBEEF_0000 | ({28'h0, i} * 32'h0000_0111);
    endfunction

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // cache victim array and main-memory read port
    assign wb_data   = wb_model(wb_idx);
    assign mem_rdata = rd_model(mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_line(input logic we, input logic [25:0] line);
        txn_t t;
        for (int i = 0; i < 16; i++) begin
            t.we    = we;
            t.addr  = {line, 4'(i), 2'b00};
            t.wdata = we ? wb_model(4'(i)) : 32'h0;
            sbq.push_back(t);
        end
    endtask

    // sample at negedge, check against scoreboard head, then advance past the next rising edge
    task automatic cyc();
        txn_t t;
        @(negedge clock);
        s_busy = busy;
        s_done = done;
        s_err  = err;
        s_req  = mem_req;
        if (sbq.size() == 0) begin
            chk("req_without_work", {31'h0, mem_req}, 32'h0);
        end else if (mem_req) begin
            t = sbq[0];
            chk("mem_addr", mem_addr, t.addr);
            chk("mem_we", {31'h0, mem_we}, {31'h0, t.we});
            if (t.we)
                chk("mem_wdata", mem_wdata, t.wdata);
            if (mem_ack) begin
                void'(sbq.pop_front());
                if (!t.we) begin
                    chk("fill_we", {31'h0, fill_we}, 32'h1);
                    chk("fill_idx", {28'h0, fill_idx}, {28'h0, t.addr[5:2]});
                    chk("fill_data", fill_data, rd_model(t.addr));
                end
            end
        end
        if (!mem_req)
            chk("fill_we_noreq", {31'h0, fill_we}, 32'h0);
        @(posedge clock);
        #1;
    endtask

    function automatic logic ack_for(input int mode, input int rel);
        case (mode)
            0:       return 1'b1;
            1:       return (rel % 3) == 0;
            default: return !(rel >= 1 && rel <= 64);
        endcase
    endfunction

    // mode 0: ack always, 1: ack every 3rd cycle, 2: ack withheld for cycles 1..64
    task automatic run_miss(input logic [25:0] ml, input logic [25:0] vl, input logic dirty,
                            input int mode, input int exp_done, input logic poke);
        int  rel      = 0;
        int  done_rel = -1;
        int  busy_cnt = 0;
        int  ndone    = 0;
        bit  fin      = 0;
        if (dirty)
            push_line(1'b1, vl);
        push_line(1'b0, ml);
        miss_line    = ml;
        victim_line  = vl;
        victim_dirty = dirty;
        miss_req     = 1'b1;
        while (!fin) begin
            mem_ack = ack_for(mode, rel);
            if (poke && (rel == 5 || rel == exp_done)) begin
                miss_req     = 1'b1;
                miss_line    = 26'h3FF_FFFF;
                victim_line  = 26'h2AA_AAAA;
                victim_dirty = 1'b1;
            end else if (rel > 0) begin
                miss_req = 1'b0;
            end
            cyc();
            if (s_busy) busy_cnt++;
            if (s_done) begin
                ndone++;
                done_rel = rel;
            end
            if (rel == 0) chk("busy_cycle0", {31'h0, s_busy}, 32'h0);
            if (rel == 1) chk("busy_cycle1", {31'h0, s_busy}, 32'h1);
            if (mode == 2 && rel == 64) chk("err_before_timeout", {31'h0, s_err}, 32'h0);
            if (mode == 2 && rel == 65) begin
                chk("err_at_timeout", {31'h0, s_err}, 32'h1);
                chk("req_at_timeout", {31'h0, s_req}, 32'h1);
            end
            if (done_rel >= 0 && rel == done_rel + 1) begin
                chk("busy_after_done", {31'h0, s_busy}, 32'h0);
                fin = 1;
            end else if (rel > 400) begin
                chk("done_within_budget", 32'(done_rel), 32'(exp_done));
                fin = 1;
            end
            rel++;
        end
        miss_req = 1'b0;
        mem_ack  = 1'b0;
        chk("done_cycle", 32'(done_rel), 32'(exp_done));
        chk("busy_cycles", 32'(busy_cnt), 32'(exp_done));
        chk("done_pulses", 32'(ndone), 32'd1);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    initial begin
        resetn       = 1'b0;
        miss_req     = 1'b0;
        miss_line    = '0;
        victim_dirty = 1'b0;
        victim_line  = '0;
        mem_ack      = 1'b0;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wb_idx", {28'h0, wb_idx}, 32'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        cyc();

        // clean miss, ack always high; ack in IDLE must be ignored
        run_miss(26'h000_0002, 26'h0, 1'b0, 0, 17, 1'b0);
        // dirty miss: write-back 0x1000..0x103C then refill 0x1040..0x107C
        run_miss(26'h000_0041, 26'h000_0040, 1'b1, 0, 33, 1'b0);
        // miss_req while busy and on the done cycle is dropped
        run_miss(26'h000_0123, 26'h0, 1'b0, 0, 17, 1'b1);
        // slow memory, ack every third cycle
        run_miss(26'h000_0002, 26'h0, 1'b0, 1, 49, 1'b0);
        chk("err_after_slow", {31'h0, err}, 32'h0);
        // ack withheld 64 cycles in FILL
        run_miss(26'h000_0077, 26'h0, 1'b0, 2, 81, 1'b0);
        chk("err_sticky", {31'h0, err}, 32'h1);

        // reset mid-FILL with cnt = 7
        push_line(1'b0, 26'h000_0005);
        miss_line    = 26'h000_0005;
        victim_dirty = 1'b0;
        miss_req     = 1'b1;
        mem_ack      = 1'b1;
        cyc();
        miss_req = 1'b0;
        repeat (7) cyc();
        chk("sb_mid_fill", 32'(sbq.size()), 32'd9);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_req", {31'h0, mem_req}, 32'h0);
        chk("arst_fill_we", {31'h0, fill_we}, 32'h0);
        chk("arst_err", {31'h0, err}, 32'h0);
        sbq.delete();
        repeat (3) begin
            cyc();
            chk("arst_no_done", {31'h0, s_done}, 32'h0);
        end
        resetn  = 1'b1;
        mem_ack = 1'b0;
        cyc();
        // restart must begin at word 0
        run_miss(26'h000_0005, 26'h0, 1'b0, 0, 17, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
